// File: rtl/vga_console_pkg.sv
// Shared constants and helpers for the vgaconsole text pixel path.
//   Geometry: 32x16 cells of 32x48 px, 8x12 glyphs at 4x scale.
//   glyph_index(): 7-bit character code -> 6-bit font ROM index.
package vga_console_pkg;
  localparam int GLYPH_W          = 8;
  localparam int GLYPH_H          = 12;
  localparam int SCALE_SHIFT      = 2;
  localparam int COLS             = 32;
  localparam int ROWS             = 16;
  localparam int ADDR_W           = 9;
  localparam int CODE_W           = 7;
  localparam int RGB_W            = 6;
  localparam int CURSOR_ROW_FIRST = 10;

  // 0x20..0x5F -> 0..63; 0x60..0x7F fold onto 0x40..0x5F so lowercase shows
  // as uppercase. Control codes (0x00..0x1F) are masked by the caller.
  function automatic logic [5:0] glyph_index(input logic [CODE_W-1:0] code);
    logic [CODE_W-1:0] c;
    c = (code[6:5] == 2'b11) ? code - 7'h20 : code;
    return 6'(c - 7'h20);
  endfunction
endpackage

// File: rtl/font_rom_8x12.sv
// Combinational 8x12 font ROM.
//   glyph : 6-bit glyph index (code 0x20 + glyph)
//   row   : glyph row 0..11 (12..15 read as 0)
//   bits  : row bitmap, bit 7 is the leftmost pixel
// Glyph 0 (space) is empty; '0', 'A' and 'H' carry full bitmaps and every
// other glyph is drawn as a hollow box.
module font_rom_8x12 (
  input  logic [5:0] glyph,
  input  logic [3:0] row,
  output logic [7:0] bits
);
  localparam logic [0:11][7:0] G_ZERO = {8'h00, 8'h3C, 8'h66, 8'h6E, 8'h76, 8'h66,
                                         8'h66, 8'h66, 8'h3C, 8'h00, 8'h00, 8'h00};
  localparam logic [0:11][7:0] G_A    = {8'h00, 8'h18, 8'h3C, 8'h66, 8'h66, 8'h7E,
                                         8'h66, 8'h66, 8'h66, 8'h00, 8'h00, 8'h00};
  localparam logic [0:11][7:0] G_H    = {8'h00, 8'h66, 8'h66, 8'h66, 8'h7E, 8'h66,
                                         8'h66, 8'h66, 8'h66, 8'h00, 8'h00, 8'h00};
  localparam logic [0:11][7:0] G_BOX  = {8'h00, 8'h7E, 8'h42, 8'h42, 8'h42, 8'h42,
                                         8'h42, 8'h42, 8'h42, 8'h7E, 8'h00, 8'h00};

  always_comb begin
    bits = 8'h00;
    if (row < 4'd12) begin
      case (glyph)
        6'd0:    bits = 8'h00;
        6'd16:   bits = G_ZERO[row];
        6'd33:   bits = G_A[row];
        6'd40:   bits = G_H[row];
        default: bits = G_BOX[row];
      endcase
    end
  end
endmodule

// File: rtl/vga_text_render.sv
// Text-mode pixel generator behind the VGA timing generator.
//   clk/rst          : pixel clock, synchronous active-high reset
//   x_hi/x_lo,y_hi/y_lo : split coordinates (cell index / pixel in cell)
//   hsync_in/vsync_in/blank_in : timing generator outputs
//   char_addr/char_data : text buffer read port (data one clk after addr)
//   fg_color/bg_color : RRGGBB colours, cursor_en/cursor_pos : cursor
//   rgb/hsync/vsync  : pixel and syncs, all delayed by the same 3 stages
module vga_text_render
  import vga_console_pkg::*;
#(
  parameter int BLINK_BIT = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] x_hi,
  input  logic [4:0] x_lo,
  input  logic [4:0] y_hi,
  input  logic [5:0] y_lo,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       blank_in,
  output logic [8:0] char_addr,
  input  logic [6:0] char_data,
  input  logic [5:0] fg_color,
  input  logic [5:0] bg_color,
  input  logic       cursor_en,
  input  logic [8:0] cursor_pos,
  output logic [5:0] rgb,
  output logic       hsync,
  output logic       vsync
);
  logic [2:0] s1_col, s2_col;
  logic [3:0] s1_row, s2_row;
  logic       s1_cur, s2_cur, s1_blank, s2_blank;
  logic       s1_hs, s2_hs, s1_vs, s2_vs;
  logic [5:0] frame_cnt;
  logic       vs_prev;
  logic [5:0] gidx;
  logic [7:0] rom_bits;
  logic       ctrl_code, cursor_row, cursor_hit, pix;
  logic       unused_lsbs;

  // Sub-pixel bits of the 4x scaling never select anything.
  assign unused_lsbs = ^{x_lo[1:0], y_lo[1:0]};

  // S1 captures the address and side info; S2 waits out the buffer latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      char_addr <= '0;
      s1_col <= '0; s1_row <= '0; s1_cur <= 1'b0;
      s1_blank <= 1'b1; s1_hs <= 1'b1; s1_vs <= 1'b0;
      s2_col <= '0; s2_row <= '0; s2_cur <= 1'b0;
      s2_blank <= 1'b1; s2_hs <= 1'b1; s2_vs <= 1'b0;
    end else begin
      char_addr <= {y_hi[3:0], x_hi[4:0]};
      s1_col    <= x_lo[4:2];
      s1_row    <= y_lo[5:2];
      s1_cur    <= ({y_hi[3:0], x_hi[4:0]} == cursor_pos);
      s1_blank  <= blank_in | x_hi[5] | y_hi[4];
      s1_hs     <= hsync_in;
      s1_vs     <= vsync_in;
      s2_col    <= s1_col;
      s2_row    <= s1_row;
      s2_cur    <= s1_cur;
      s2_blank  <= s1_blank;
      s2_hs     <= s1_hs;
      s2_vs     <= s1_vs;
    end
  end

  // Frame counter steps once per vsync_in rising edge, however long it stays high.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      vs_prev   <= 1'b0;
    end else begin
      vs_prev <= vsync_in;
      if (vsync_in && !vs_prev) frame_cnt <= frame_cnt + 6'd1;
    end
  end

  assign gidx = glyph_index(char_data);

  font_rom_8x12 u_font (
    .glyph (gidx),
    .row   (s2_row),
    .bits  (rom_bits)
  );

  // The output stage reads the registered frame_cnt, so a pixel coinciding
  // with a vsync rising edge still sees the pre-increment blink phase.
  assign ctrl_code  = (char_data[6:5] == 2'b00);
  assign cursor_row = (s2_row == 4'(CURSOR_ROW_FIRST)) || (s2_row == 4'(CURSOR_ROW_FIRST + 1));
  assign cursor_hit = cursor_en & s2_cur & cursor_row & ~frame_cnt[BLINK_BIT];
  assign pix        = (~ctrl_code & rom_bits[3'd7 - s2_col]) ^ cursor_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb   <= '0;
      hsync <= 1'b1;
      vsync <= 1'b0;
    end else begin
      rgb   <= s2_blank ? '0 : (pix ? fg_color : bg_color);
      hsync <= s2_hs;
      vsync <= s2_vs;
    end
  end
endmodule
